// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with tear-free display-word updates.
// Define SEG7_LZ_BLANK_EN to darken leading-zero digits (digit 0 always lit).
module seg7_scan_ctrl #(
  parameter int DWELL        = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  dig_code,
  output logic [3:0]  ga,
  output logic [1:0]  digit_idx,
  output logic        frame_done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        disp_q, disp_d;
  logic [15:0]        pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
  logic [3:0]         ga_q, ga_d;
  logic [3:0]         dig_q, dig_d;
  logic               fd_q, fd_d;
  logic               start_frame;
  logic               wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      disp_q   <= 16'h0000;
      pend_q   <= 16'h0000;
      pend_v_q <= 1'b0;
      ga_q     <= 4'b1111;
      dig_q    <= 4'h0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ga_q     <= ga_d;
      dig_q    <= dig_d;
      fd_q     <= fd_d;
    end
  end

  // start_frame marks every entry into SHOW idx 0; wrap only the ones coming from digit 3.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    start_frame = 1'b0;
    wrap        = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d     = SHOW;
          idx_d       = 2'd0;
          cnt_d       = '0;
          start_frame = 1'b1;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
          end else begin
            idx_d       = idx_q + 2'd1;
            start_frame = (idx_q == 2'd3);
            wrap        = (idx_q == 2'd3);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d     = SHOW;
          idx_d       = idx_q + 2'd1;
          cnt_d       = '0;
          start_frame = (idx_q == 2'd3);
          wrap        = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    disp_d   = disp_q;
    ga_d     = 4'b1111;
    dig_d    = dig_q;
    fd_d     = wrap;
    if (load) begin
      pend_d   = value;
      pend_v_d = 1'b1;
    end
    // A load coinciding with the frame boundary bypasses the pending register.
    if (start_frame) begin
      if (load) begin
        disp_d = value;
      end else if (pend_v_q) begin
        disp_d = pend_q;
      end
      pend_v_d = 1'b0;
    end
    if (state_d == SHOW) begin
      ga_d  = ~(4'b0001 << idx_d);
      dig_d = disp_d[{idx_d, 2'b00} +: 4];
`ifdef SEG7_LZ_BLANK_EN
      if ((idx_d != 2'd0) && ((disp_d >> {idx_d, 2'b00}) == 16'h0000)) begin
        ga_d = 4'b1111;
      end
`else
`endif
    end
  end

  assign dig_code   = dig_q;
  assign ga         = ga_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;
  assign state_dbg  = state_q;

endmodule
